branch_ctrl: RTL and testbench

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/hazard_detect.sv | 17 +
 rtl/branch_ctrl.sv | 116 +++++++++++
 tb/tb_branch_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, PC-select encodings and the branch
// controller state type.
package cpu_pkg;

  localparam logic [5:0] OP_BEQ = 6'd32;
  localparam logic [5:0] OP_BNE = 6'd33;
  localparam logic [5:0] OP_BLT = 6'd34;
  localparam logic [5:0] OP_BLE = 6'd35;
  localparam logic [5:0] OP_J   = 6'd40;
  localparam logic [5:0] OP_JAL = 6'd41;
  localparam logic [5:0] OP_JR  = 6'd42;
  localparam logic [5:0] OP_HLT = 6'd63;

  localparam logic [1:0] PCSEL_SEQ    = 2'b00;
  localparam logic [1:0] PCSEL_JUMP   = 2'b01;
  localparam logic [1:0] PCSEL_BRANCH = 2'b10;
  localparam logic [1:0] PCSEL_HOLD   = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_HALT    = 2'd3
  } br_state_e;

  // Conditional branches and JR share the same EX-resolved path.
  function automatic logic is_ex_resolved(input logic [5:0] op);
    return (op >= OP_BEQ && op <= OP_BLE) || (op == OP_JR);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard check between the EX-stage load and the ID-stage sources.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic       load_ex_i,
  input  logic       valid_id_i,
  input  logic [4:0] rd_ex_i,
  input  logic [4:0] rs_id_i,
  input  logic [4:0] rt_id_i,
  output logic       hazard_o
);

  // Register 0 is hardwired zero, so a load to it never creates a dependency.
  assign hazard_o = load_ex_i & valid_id_i & (rd_ex_i != 5'd0) &
                    ((rd_ex_i == rs_id_i) | (rd_ex_i == rt_id_i));

endmodule

// File: rtl/branch_ctrl.sv
// Front-end control: PC select, IF/ID stall/flush and ID/EX bubble for
// load-use hazards, jumps, EX-resolved branches/JR and halt.
//
// state   | meaning
// RUN     | normal decode of the ID-stage instruction
// WAIT    | branch/JR decoded, waiting for it to reach EX
// RESOLVE | branch outcome available in EX, redirect or continue
// HALT    | processor stopped until reset
module branch_ctrl
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rstd,
  input  logic       valid_id,
  input  logic [5:0] op_id,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       load_ex,
  input  logic [4:0] rd_ex,
  input  logic       taken_ex,
  output logic [1:0] pc_sel,
  output logic       stall_if,
  output logic       bubble_ex,
  output logic       flush_id,
  output logic       halted,
  output logic       busy
);

  br_state_e state_q, state_d;
  logic      is_jr_q, is_jr_d;
  logic      load_use;

  hazard_detect u_hazard_detect (
    .load_ex_i  (load_ex),
    .valid_id_i (valid_id),
    .rd_ex_i    (rd_ex),
    .rs_id_i    (rs_id),
    .rt_id_i    (rt_id),
    .hazard_o   (load_use)
  );

  always_ff @(posedge clk) begin
    if (rstd) begin
      state_q <= ST_RUN;
      is_jr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_jr_q <= is_jr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    is_jr_d   = is_jr_q;
    pc_sel    = PCSEL_SEQ;
    stall_if  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    halted    = 1'b0;
    busy      = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (load_use) begin
          pc_sel    = PCSEL_HOLD;
          stall_if  = 1'b1;
          bubble_ex = 1'b1;
        end else if (valid_id) begin
          if (op_id == OP_HLT) begin
            pc_sel   = PCSEL_HOLD;
            flush_id = 1'b1;
            state_d  = ST_HALT;
          end else if (op_id == OP_J || op_id == OP_JAL) begin
            pc_sel   = PCSEL_JUMP;
            flush_id = 1'b1;
          end else if (is_ex_resolved(op_id)) begin
            pc_sel   = PCSEL_HOLD;
            flush_id = 1'b1;
            is_jr_d  = (op_id == OP_JR);
            state_d  = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        pc_sel   = PCSEL_HOLD;
        flush_id = 1'b1;
        busy     = 1'b1;
        state_d  = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        busy    = 1'b1;
        state_d = ST_RUN;
        if (is_jr_q || taken_ex) begin
          pc_sel   = PCSEL_BRANCH;
          flush_id = 1'b1;
        end
      end
      default: begin
        pc_sel   = PCSEL_HOLD;
        stall_if = 1'b1;
        halted   = 1'b1;
      end
    endcase

    // While reset is held the outputs look like an idle RUN cycle.
    if (rstd) begin
      pc_sel    = PCSEL_SEQ;
      stall_if  = 1'b0;
      bubble_ex = 1'b0;
      flush_id  = 1'b0;
      halted    = 1'b0;
      busy      = 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl.
module tb_branch_ctrl;

  logic       clk = 1'b0;
  logic       rstd;
  logic       valid_id;
  logic [5:0] op_id;
  logic [4:0] rs_id, rt_id, rd_ex;
  logic       load_ex, taken_ex;
  logic [1:0] pc_sel;
  logic       stall_if, bubble_ex, flush_id, halted, busy;

  int tests = 0;
  int fails = 0;

  branch_ctrl dut (
    .clk       (clk),
    .rstd      (rstd),
    .valid_id  (valid_id),
    .op_id     (op_id),
    .rs_id     (rs_id),
    .rt_id     (rt_id),
    .load_ex   (load_ex),
    .rd_ex     (rd_ex),
    .taken_ex  (taken_ex),
    .pc_sel    (pc_sel),
    .stall_if  (stall_if),
    .bubble_ex (bubble_ex),
    .flush_id  (flush_id),
    .halted    (halted),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // exp = {pc_sel, stall_if, bubble_ex, flush_id, halted, busy}
  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    #1;
    obs = {pc_sel, stall_if, bubble_ex, flush_id, halted, busy};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic ld, input logic [4:0] rd,
                       input logic tk);
    valid_id = v; op_id = op; rs_id = rs; rt_id = rt;
    load_ex = ld; rd_ex = rd; taken_ex = tk;
  endtask

  initial begin
    rstd = 1'b1;
    drive(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    chk("reset_held", 7'b00_00000);
    tick(); tick();
    rstd = 1'b0;
    chk("post_reset", 7'b00_00000);

    // Load-use on rs, then cleared.
    drive(1'b1, 6'd0, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0);
    chk("loaduse_rs", 7'b11_11000);
    tick();
    load_ex = 1'b0;
    chk("loaduse_clear", 7'b00_00000);
    drive(1'b1, 6'd0, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0);
    chk("loaduse_rt", 7'b11_11000);
    drive(1'b1, 6'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    chk("loaduse_r0", 7'b00_00000);
    drive(1'b0, 6'd0, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0);
    chk("loaduse_invalid", 7'b00_00000);
    drive(1'b0, 6'd32, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("invalid_br", 7'b00_00000);
    tick();
    chk("invalid_br_stay", 7'b00_00000);

    // Taken BEQ, with HLT presented in the WAIT shadow.
    drive(1'b1, 6'd32, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("beq_decode", 7'b11_00100);
    tick();
    drive(1'b1, 6'd63, 5'd3, 5'd3, 1'b1, 5'd3, 1'b0);
    chk("beq_wait_hlt", 7'b11_00101);
    tick();
    drive(1'b1, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
    chk("beq_resolve", 7'b10_00101);
    tick();
    taken_ex = 1'b0;
    chk("beq_back_run", 7'b00_00000);

    // Not-taken BNE.
    op_id = 6'd33;
    chk("bne_decode", 7'b11_00100);
    tick(); op_id = 6'd0;
    chk("bne_wait", 7'b11_00101);
    tick();
    chk("bne_resolve", 7'b00_00001);
    tick();

    // JR redirects regardless of taken_ex.
    op_id = 6'd42;
    chk("jr_decode", 7'b11_00100);
    tick(); op_id = 6'd40;
    chk("jr_wait_j", 7'b11_00101);
    tick(); op_id = 6'd0;
    chk("jr_resolve", 7'b10_00101);
    tick();

    // BLE after JR: is_jr must be re-latched low.
    op_id = 6'd35;
    tick(); op_id = 6'd0;
    tick();
    chk("ble_nt_resolve", 7'b00_00001);
    tick();

    // Jumps stay in RUN.
    op_id = 6'd40;
    chk("j_decode", 7'b01_00100);
    tick(); op_id = 6'd41;
    chk("jal_decode", 7'b01_00100);
    tick(); op_id = 6'd36;
    chk("seq_op36", 7'b00_00000);

    // Load-use outranks HLT; state must not move to HALT.
    drive(1'b1, 6'd63, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0);
    chk("loaduse_over_hlt", 7'b11_11000);
    tick();
    drive(1'b1, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("no_halt_after_lu", 7'b00_00000);

    // Reset held for 2 cycles mid-RESOLVE.
    op_id = 6'd34;
    tick(); op_id = 6'd0;
    tick();
    taken_ex = 1'b1;
    chk("pre_reset_resolve", 7'b10_00101);
    rstd = 1'b1;
    chk("reset_in_resolve", 7'b00_00000);
    tick(); tick();
    rstd = 1'b0;
    chk("reset_resolve_after", 7'b00_00000);
    tick();
    taken_ex = 1'b0;
    chk("reset_resolve_run", 7'b00_00000);

    // Halt, then 20 cycles of random inputs.
    op_id = 6'd63;
    chk("hlt_decode", 7'b11_00100);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(1'($urandom), 6'($urandom), 5'($urandom), 5'($urandom),
            1'($urandom), 5'($urandom), 1'($urandom));
      chk($sformatf("halt_hold_%0d", i), 7'b11_10010);
      tick();
    end
    rstd = 1'b1;
    chk("halt_reset_held", 7'b00_00000);
    tick();
    rstd = 1'b0;
    drive(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("halt_reset_exit", 7'b00_00000);
    tick();
    chk("halt_reset_run", 7'b00_00000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
